interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
Collects up to NUM_SRC interrupt request lines and latches them as pending. Applies a mask and a global enable, then picks one source. Sequences the single-level interrupt handshake with programCounter: a one-cycle intr pulse out, and a wait for reti from the decoder before the next interrupt may fire. Software configures and inspects it through a 2-bit-addressed register port driven by the memory-mapped IO decode.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..15)
ID_W, 4, width of the source-ID field in CAUSE (must satisfy 2^ID_W >= NUM_SRC)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
irq_in  in  NUM_SRC  request lines, synchronous to clk, rising-edge sensitive
reti  in  1  return-from-interrupt strobe from decoder (same signal fed to programCounter)
cfg_we  in  1  register write strobe
cfg_addr  in  2  register select: 0 CTRL, 1 MASK, 2 PENDING, 3 CAUSE
cfg_wdata  in  16  write data
cfg_rdata  out  16  combinational read data for cfg_addr
intr  out  1  one-cycle interrupt request to programCounter, registered
in_service  out  1  high from the intr cycle until reti is accepted

Behaviour:
- Reset (async, immediate):
  - intr=0, in_service=0
  - CTRL.GIE=0, MASK=0, PENDING=0, CAUSE=0, irq_q=0
  - FSM=IDLE
  - cfg_rdata reflects the reset register values.
- Edge detect:
  - irq_q <= irq_in every cycle.
  - Rising edge = irq_in & ~irq_q; the corresponding PENDING bit is set at that edge.
- PENDING write, W1C:
  - Writing 1 to a bit clears it.
  - If a rising edge and a W1C clear hit the same bit in the same cycle, set wins.
- CTRL: bit0 = GIE (RW); bits 15:1 read 0.
- MASK: bits NUM_SRC-1:0 RW, 1 = enabled; unused bits read 0.
- CAUSE (read-only except flag clear):
  - [ID_W-1:0] = ID of the last taken source.
  - bit15 = in_service.
  - bit14 = sticky SPURIOUS flag; any write to CAUSE clears it.
- eligible = PENDING & MASK.
- FSM IDLE:
  - Fires when GIE=1, eligible!=0 and reti=0.
  - Selects the winner (fixed priority: lowest index wins).
  - At that edge: intr<=1, PENDING[winner]<=0 (overrides a same-cycle set of that bit), CAUSE.ID<=winner, state<=FIRE.
- FSM FIRE:
  - intr is high for exactly this one cycle.
  - Next edge: intr<=0, state<=SERVICE.
  - in_service=1 from FIRE onward.
- FSM SERVICE:
  - Waits for reti.
  - On reti: state<=IDLE, in_service<=0.
  - Earliest next intr is the cycle after IDLE is re-entered, so there is at least one non-intr cycle between reti and the next intr.
  - New edges keep accumulating in PENDING meanwhile. There is no nesting: programCounter stores only one return address.
- reti in FIRE: treated as in SERVICE (returns to IDLE); SPURIOUS is not set.
- reti in IDLE: ignored except SPURIOUS<=1.
- GIE cleared in FIRE or SERVICE: does not abort the sequence; only blocks new selections.
- Latency: irq_in rising at edge k (low at k-1) -> PENDING set after k -> intr high in the cycle after edge k+1, given IDLE, GIE=1 and bit unmasked.
- Masked pending bits stay pending and fire once unmasked.

Optional Feature:
- Macro INTC_ROUND_ROBIN_EN.
- Defined:
  - Arbitration is round-robin over eligible, starting from (last taken ID + 1) mod NUM_SRC.
  - The pointer is held in a register, reset to 0, and updated only when a source is taken.
- Undefined: fixed priority, lowest index wins; no pointer register.
- Register map and all handshake timing are identical in both builds.

Test Plan:
1. Reset, GIE=1, MASK=0x01, pulse irq_in[0] at edge k -> intr=1 only in the cycle after k+1; CAUSE=0x8000; PENDING=0.
2. irq_in[3] and irq_in[1] rise in the same cycle, MASK=0xFF -> first intr has CAUSE.ID=1. After reti, next intr has CAUSE.ID=3, with at least one intr-free cycle in between.
3. MASK=0x00, pulse irq_in[2] -> no intr, PENDING=0x0004; write MASK=0x04 -> intr fires, ID=2; W1C of bit 2 in the same cycle as a new edge -> bit stays set.
4. Apply reti in IDLE -> CAUSE bit14=1, no state change; write CAUSE -> bit14=0.
5. Assert rst mid-SERVICE -> intr=0, in_service=0, all registers 0 with no clock edge required.
6. With INTC_ROUND_ROBIN_EN, keep irq 0 and 1 re-pulsed continuously -> taken IDs alternate 0,1,0,1; without the macro -> always 0.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched interrupt sources, mask/GIE gating and single-level intr/reti handshake.
// Define INTC_ROUND_ROBIN_EN for round-robin arbitration instead of lowest-index-wins priority.
module interrupt_controller #(
   parameter int NUM_SRC = 8,
   parameter int ID_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               reti,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [15:0]        cfg_wdata,
   output logic [15:0]        cfg_rdata,
   output logic               intr,
   output logic               in_service
);
   typedef enum logic [1:0] {IDLE, FIRE, SERVICE} state_t;
   state_t state, state_n;
   logic gie, spurious, take, unused_wdata;
   logic [NUM_SRC-1:0] mask, pending, pending_n, irq_q, eligible, w1c, taken_bit;
   logic [ID_W-1:0] cause_id, winner;

   assign eligible = pending & mask;
   assign take = state == IDLE && gie && |eligible && !reti;
   assign w1c = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[NUM_SRC-1:0] : '0;
   assign taken_bit = take ? NUM_SRC'(1) << winner : '0;
   // the taken source is cleared even if it re-rises this cycle; other edges beat W1C
   assign pending_n = ((pending & ~w1c) | (irq_in & ~irq_q)) & ~taken_bit;
   assign intr = state == FIRE;
   assign in_service = state != IDLE;
   assign unused_wdata = ^cfg_wdata;
   assign cfg_rdata = cfg_addr == 2'd0 ? {15'd0, gie}
                    : cfg_addr == 2'd1 ? 16'(mask)
                    : cfg_addr == 2'd2 ? 16'(pending)
                    : {in_service, spurious, 14'(cause_id)};

`ifdef INTC_ROUND_ROBIN_EN
   logic found;
   logic [ID_W-1:0] ptr;
   logic [NUM_SRC-1:0] rot;
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (take) ptr <= ID_W'((int'(winner) + 1) % NUM_SRC);
   always_comb begin
      winner = '0;
      found = 1'b0;
      rot = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rot = eligible >> ((int'(ptr) + i) % NUM_SRC);
         if (!found && rot[0]) begin
            winner = ID_W'((int'(ptr) + i) % NUM_SRC);
            found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (eligible[i]) winner = ID_W'(i);
   end
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = take ? FIRE : IDLE;
         FIRE:    state_n = reti ? IDLE : SERVICE;
         default: state_n = reti ? IDLE : SERVICE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         gie <= 1'b0;
         mask <= '0;
         pending <= '0;
         irq_q <= '0;
         cause_id <= '0;
         spurious <= 1'b0;
      end else begin
         irq_q <= irq_in;
         pending <= pending_n;
         if (cfg_we && cfg_addr == 2'd0) gie <= cfg_wdata[0];
         if (cfg_we && cfg_addr == 2'd1) mask <= cfg_wdata[NUM_SRC-1:0];
         if (take) cause_id <= winner;
         if (state == IDLE && reti) spurious <= 1'b1;
         else if (cfg_we && cfg_addr == 2'd3) spurious <= 1'b0;
      end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed bench with an expected-ID scoreboard for interrupt_controller.
module tb_interrupt_controller;
   logic clk = 1'b0, rst = 1'b1, reti = 1'b0, cfg_we = 1'b0;
   logic intr, in_service;
   logic [7:0] irq_in = '0;
   logic [1:0] cfg_addr = 2'd3;
   logic [15:0] cfg_wdata = '0, cfg_rdata;
   int checks = 0, errors = 0;
   logic [3:0] sb[$];

   interrupt_controller #(.NUM_SRC(8), .ID_W(4)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .reti(reti), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
      .intr(intr), .in_service(in_service)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [15:0] v);
      cfg_addr = a;
      #1;
      v = cfg_rdata;
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
      logic [15:0] v;
      rd(a, v);
      chk(tag, v, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic expect_intr(input string tag, input int budget);
      int n = 0;
      logic [15:0] v;
      while (intr !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_intr"}, 16'(intr), 16'd1);
      chk({tag, "_sb_nonempty"}, 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
         rd(2'd3, v);
         chk({tag, "_id"}, {12'd0, v[3:0]}, {12'd0, sb.pop_front()});
      end
   endtask

   initial begin
      tick();
      tick();
      chk("rst_intr", 16'(intr), 16'd0);
      chk("rst_in_service", 16'(in_service), 16'd0);
      chk_reg("rst_ctrl", 2'd0, 16'h0000);
      chk_reg("rst_mask", 2'd1, 16'h0000);
      chk_reg("rst_pending", 2'd2, 16'h0000);
      chk_reg("rst_cause", 2'd3, 16'h0000);
      rst = 1'b0;
      tick();
      // basic latency
      wr(2'd0, 16'h0001);
      wr(2'd1, 16'h0001);
      chk_reg("t1_ctrl", 2'd0, 16'h0001);
      sb.push_back(4'd0);
      irq_in = 8'h01;
      tick();
      chk("t1_no_intr_after_k", 16'(intr), 16'd0);
      chk_reg("t1_pending_set", 2'd2, 16'h0001);
      irq_in = 8'h00;
      tick();
      chk("t1_intr_after_k1", 16'(intr), 16'd1);
      chk_reg("t1_cause", 2'd3, 16'h8000);
      chk_reg("t1_pending_clr", 2'd2, 16'h0000);
      expect_intr("t1", 0);
      tick();
      chk("t1_intr_one_cycle", 16'(intr), 16'd0);
      chk("t1_in_service", 16'(in_service), 16'd1);
      reti = 1'b1;
      tick();
      reti = 1'b0;
      chk("t1_reti_done", 16'(in_service), 16'd0);
      chk_reg("t1_cause_idle", 2'd3, 16'h0000);
      // simultaneous sources, priority and gap
      wr(2'd1, 16'h00FF);
      sb.push_back(4'd1);
      sb.push_back(4'd3);
      irq_in = 8'h0A;
      tick();
      irq_in = 8'h00;
      expect_intr("t2a", 4);
      tick();
      reti = 1'b1;
      tick();
      reti = 1'b0;
      chk("t2_gap", 16'(intr), 16'd0);
      chk_reg("t2_pending_left", 2'd2, 16'h0008);
      expect_intr("t2b", 4);
      chk_reg("t2_pending_empty", 2'd2, 16'h0000);
      tick();
      reti = 1'b1;
      tick();
      reti = 1'b0;
      // masked pending, unmask, set beats W1C
      wr(2'd1, 16'h0000);
      irq_in = 8'h04;
      tick();
      irq_in = 8'h00;
      tick();
      tick();
      chk("t3_masked_no_intr", 16'(intr), 16'd0);
      chk_reg("t3_pending_masked", 2'd2, 16'h0004);
      sb.push_back(4'd2);
      wr(2'd1, 16'h0004);
      expect_intr("t3", 4);
      chk_reg("t3_pending_taken", 2'd2, 16'h0000);
      tick();
      reti = 1'b1;
      tick();
      reti = 1'b0;
      wr(2'd1, 16'h0000);
      irq_in = 8'h04;
      tick();
      irq_in = 8'h00;
      tick();
      irq_in = 8'h04;
      wr(2'd2, 16'h0004);
      irq_in = 8'h00;
      chk_reg("t3_set_wins", 2'd2, 16'h0004);
      wr(2'd2, 16'h0004);
      chk_reg("t3_w1c", 2'd2, 16'h0000);
      // spurious reti
      reti = 1'b1;
      tick();
      reti = 1'b0;
      chk_reg("t4_spurious", 2'd3, 16'h4002);
      chk("t4_no_service", 16'(in_service), 16'd0);
      chk("t4_no_intr", 16'(intr), 16'd0);
      wr(2'd3, 16'h0000);
      chk_reg("t4_spurious_clr", 2'd3, 16'h0002);
      // async reset mid-service
      wr(2'd1, 16'h0020);
      sb.push_back(4'd5);
      irq_in = 8'h60;
      tick();
      irq_in = 8'h00;
      expect_intr("t5", 4);
      tick();
      chk("t5_in_service", 16'(in_service), 16'd1);
      chk_reg("t5_pending", 2'd2, 16'h0040);
      rst = 1'b1;
      #1;
      chk("t5_rst_intr", 16'(intr), 16'd0);
      chk("t5_rst_in_service", 16'(in_service), 16'd0);
      chk_reg("t5_rst_ctrl", 2'd0, 16'h0000);
      chk_reg("t5_rst_mask", 2'd1, 16'h0000);
      chk_reg("t5_rst_pending", 2'd2, 16'h0000);
      chk_reg("t5_rst_cause", 2'd3, 16'h0000);
      tick();
      rst = 1'b0;
      tick();
      // arbitration with two continuously re-pulsed sources
      wr(2'd0, 16'h0001);
      wr(2'd1, 16'h0003);
      irq_in = 8'h03;
      tick();
      irq_in = 8'h00;
      for (int r = 0; r < 4; r++) begin
`ifdef INTC_ROUND_ROBIN_EN
         sb.push_back(4'(r % 2));
`else
         sb.push_back(4'd0);
`endif
         expect_intr($sformatf("t6_%0d", r), 5);
         tick();
         irq_in = 8'h03;
         tick();
         irq_in = 8'h00;
         reti = 1'b1;
         tick();
         reti = 1'b0;
      end
      chk("sb_empty", 16'(sb.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
